// File: rtl/fec_pkg.sv
// rtl/fec_pkg.sv - shared FSM states, default sizes and cyclic-ring multiply
package fec_pkg;

  localparam int M_DEF      = 3;
  localparam int WIDTH_DEF  = 11;
  localparam int CMUL_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_COMPUTE,
    ST_EMIT
  } state_t;

  // Product modulo x^w - 1: each set bit k of a contributes b rotated left by k within w bits.
  function automatic logic [CMUL_MAX_W-1:0] cmul(
    input logic [CMUL_MAX_W-1:0] a,
    input logic [CMUL_MAX_W-1:0] b,
    input int                    w
  );
    logic [2*CMUL_MAX_W-1:0] wide;
    logic [2*CMUL_MAX_W-1:0] mask;
    logic [CMUL_MAX_W-1:0]   acc;
    acc  = '0;
    mask = ({{(2*CMUL_MAX_W-1){1'b0}}, 1'b1} << w) - 1'b1;
    for (int k = 0; k < CMUL_MAX_W; k++) begin
      if (k < w && a[k]) begin
        wide = {{CMUL_MAX_W{1'b0}}, b} << k;
        acc  = acc ^ CMUL_MAX_W'((wide & mask) | (wide >> w));
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/fec_row_apply.sv
// rtl/fec_row_apply.sv - one decode row: XOR over columns of cmul(coeff, lifted)
module fec_row_apply
  import fec_pkg::*;
#(
  parameter int COLS = M_DEF,
  parameter int W    = WIDTH_DEF
) (
  input  logic [COLS*W-1:0] coeff_row,
  input  logic [COLS*W-1:0] lifted,
  output logic [W-1:0]      r
);

  logic [CMUL_MAX_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int j = 0; j < COLS; j++) begin
      acc = acc ^ cmul(CMUL_MAX_W'(coeff_row[j*W +: W]), CMUL_MAX_W'(lifted[j*W +: W]), W);
    end
    r = acc[W-1:0];
  end

endmodule

// File: rtl/fec_decode_sched.sv
// rtl/fec_decode_sched.sv - collects M symbols, then emits M decoded rows through one shared row unit
module fec_decode_sched
  import fec_pkg::*;
#(
  parameter int M      = M_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DATA_W = WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 cfg_we,
  input  logic [$clog2(M)-1:0] cfg_row,
  input  logic [$clog2(M)-1:0] cfg_col,
  input  logic [WIDTH-1:0]     cfg_coeff,
  output logic                 cfg_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic [$clog2(M)-1:0] m_row,
  output logic                 m_last,
  output logic                 busy
);

  localparam int IW = $clog2(M);
  localparam logic [IW-1:0] LAST = IW'(M - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt;
  logic [IW-1:0]   row;
  logic [WIDTH-1:0] lifted [M];
  logic [WIDTH-1:0] coeff  [M][M];
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] row_r;
  logic [M*WIDTH-1:0] coeff_flat;
  logic [M*WIDTH-1:0] lifted_flat;
  logic            in_hs;
  logic            out_hs;
  logic            cfg_bad;

  assign in_hs   = s_valid && (state_q == ST_COLLECT);
  assign out_hs  = m_ready && (state_q == ST_EMIT);
  assign cfg_bad = (int'(cfg_row) >= M) || (int'(cfg_col) >= M);

  always_comb begin
    coeff_flat  = '0;
    lifted_flat = '0;
    for (int j = 0; j < M; j++) begin
      coeff_flat[j*WIDTH +: WIDTH]  = coeff[row][j];
      lifted_flat[j*WIDTH +: WIDTH] = lifted[j];
    end
  end

  fec_row_apply #(.COLS(M), .W(WIDTH)) u_row_apply (
    .coeff_row (coeff_flat),
    .lifted    (lifted_flat),
    .r         (row_r)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b1;
    case (state_q)
      ST_COLLECT: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid && cnt == LAST) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: state_d = ST_EMIT;
      ST_EMIT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = (row == LAST) ? ST_COLLECT : ST_COMPUTE;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // r_q only changes in COMPUTE, so the output stays put while EMIT is stalled.
  assign m_data = (state_q == ST_EMIT) ? r_q[DATA_W-1:0] : '0;
  assign m_row  = row;
  assign m_last = (state_q == ST_EMIT) && (row == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      row     <= '0;
      r_q     <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < M; i++) begin
        lifted[i] <= '0;
        for (int j = 0; j < M; j++) begin
          coeff[i][j] <= (i == j) ? WIDTH'(1) : '0;
        end
      end
    end else begin
      cfg_err <= cfg_we && (cfg_bad || state_q != ST_COLLECT);
      if (cfg_we && !cfg_bad && state_q == ST_COLLECT) coeff[cfg_row][cfg_col] <= cfg_coeff;
      if (in_hs) begin
        lifted[cnt] <= WIDTH'({^s_data, s_data});
        if (cnt == LAST) begin
          cnt <= '0;
          row <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (state_q == ST_COMPUTE) r_q <= row_r;
      if (out_hs && row != LAST) row <= row + 1'b1;
    end
  end

endmodule

// File: doc/fec_decode_sched.md
FEC_DECODE_SCHED -- requirements
Module: fec_decode_sched

Interface
REQ-001 Parameters SHALL be: M, default 3, number of symbols per decode group.
REQ-002 Parameters SHALL be: WIDTH, default 11, cyclic-domain width with the parity bit included.
REQ-003 Parameters SHALL be: DATA_W, default WIDTH-1, data symbol width.
REQ-004 Ports SHALL be, in this order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  input symbol ready.
- s_data  in  DATA_W  input symbol.
- cfg_we  in  1  coefficient write strobe.
- cfg_row  in  $clog2(M)  coefficient row index.
- cfg_col  in  $clog2(M)  coefficient column index.
- cfg_coeff  in  WIDTH  coefficient, cyclic-ring polynomial.
- cfg_err  out  1  one-cycle pulse when a config write is rejected.
- m_valid  out  1  decoded symbol valid.
- m_ready  in  1  decoded symbol ready.
- m_data  out  DATA_W  decoded symbol.
- m_row  out  $clog2(M)  index of the decoded row.
- m_last  out  1  high with the row M-1 output.
- busy  out  1  high in COMPUTE or EMIT.

Function
REQ-005 The FSM SHALL have three states: COLLECT, COMPUTE and EMIT.
REQ-006 In COLLECT, s_ready SHALL be 1; each s_valid&&s_ready handshake stores lift(s_data) = {^s_data, s_data} into slot cnt, and cnt increments.
REQ-007 On the handshake with cnt==M-1, the block SHALL clear cnt, clear row to 0 and enter COMPUTE next cycle.
REQ-008 In COMPUTE and EMIT, s_ready SHALL be 0.
REQ-009 COMPUTE SHALL last exactly one cycle.
- It registers r = XOR over j of cmul(coeff[row][j], lifted[j]).
- cmul(a,b) is the product modulo x^WIDTH-1: XOR of b rotated left by k for each set bit k of a.
- The next state is EMIT.
REQ-010 In EMIT, the outputs SHALL be:
- m_valid = 1.
- m_data = r[DATA_W-1:0]; the top bit is dropped.
- m_row = row.
- m_last = (row==M-1).
REQ-011 m_data, m_row and m_last SHALL be held stable while m_valid && !m_ready.
REQ-012 On an EMIT handshake with row<M-1, the block SHALL increment row and go to COMPUTE; with row==M-1, it SHALL go to COLLECT.
REQ-013 Latency: the last input handshake at cycle t SHALL give m_valid at t+2; an output handshake at t SHALL give the next row's m_valid at t+2.
REQ-014 A cfg_we asserted in COLLECT SHALL write coeff[cfg_row][cfg_col]; the new value is used by any following COMPUTE.
REQ-015 A cfg_we asserted in COMPUTE or EMIT SHALL be ignored, and cfg_err SHALL pulse high the next cycle.
REQ-016 cfg_row or cfg_col >= M SHALL be ignored with a cfg_err pulse in any state.
REQ-017 A cfg_we coincident with the final input handshake SHALL take effect, because the state is still COLLECT.
REQ-018 busy SHALL equal (state != COLLECT).

Reset
REQ-019 rst SHALL force the following on the next edge, including mid-COMPUTE or mid-EMIT:
- state = COLLECT, cnt = 0, row = 0.
- m_valid = 0, m_data = 0, m_row = 0, m_last = 0.
- cfg_err = 0, busy = 0, s_ready = 1.
REQ-020 rst SHALL load the coefficients with the identity matrix: coeff[i][i] = 1, all others 0.
REQ-021 rst SHALL zero the lifted-symbol slots; partial groups are discarded.

Structure
REQ-022 A shared package fec_pkg SHALL hold:
- the state enum;
- the default M/WIDTH constants;
- a cmul function.
REQ-023 One sub-module fec_row_apply (COLS=M, W=WIDTH) SHALL compute a single row combinationally; the controller instantiates it once and time-multiplexes it across rows.

Verification (M=3, WIDTH=11)
REQ-024 After reset, inputs 0x001, 0x3FF, 0x155 SHALL produce m_data 0x001, 0x3FF, 0x155, with m_row 0,1,2 and m_last only on row 2.
REQ-025 Writing coeff[0][0]=0x002 then sending 0x001, 0x002, 0x004 SHALL give row0 = 0x003 (0x401 rotated to 0x003), row1 = 0x002, row2 = 0x004.
REQ-026 With coeff row0 = [1,1,1] and inputs 0x001, 0x002, 0x004, row0 SHALL be 0x007.
REQ-027 Holding m_ready=0 for 5 cycles in EMIT SHALL keep m_valid=1 and m_data unchanged, with s_ready=0 throughout.
REQ-028 A cfg_we during EMIT SHALL pulse cfg_err once and leave the coefficient unchanged.
REQ-029 Asserting rst during EMIT row 1 SHALL give:
- m_valid=0 and s_ready=1 next cycle;
- the subsequent group passes through the identity matrix.
